// File: rtl/lcd_pkg.sv
// ============================================================================
// Module : lcd_pkg
// Desc   : Shared types and constants for the LCD message scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lcd_pkg;

  localparam int ROW_W = 128;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  localparam logic [1:0] SRC_KEY    = 2'd0;
  localparam logic [1:0] SRC_STATUS = 2'd1;
  localparam logic [1:0] SRC_ALARM  = 2'd2;
  localparam logic [1:0] SRC_IDLE   = 2'd3;

  localparam logic [ROW_W-1:0] BANNER_ROW1 = "  DIGITAL LOCK  ";
  localparam logic [ROW_W-1:0] BANNER_ROW2 = "  ENTER CODE    ";

  // Highest set request bit wins; SRC_IDLE when nothing is requested.
  function automatic logic [1:0] hi_idx(input logic [2:0] r);
    if (r[2])      return SRC_ALARM;
    else if (r[1]) return SRC_STATUS;
    else if (r[0]) return SRC_KEY;
    else           return SRC_IDLE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_hold_timer.sv
// ============================================================================
// Module : lcd_hold_timer
// Desc   : Loadable down-counter with enable/freeze and a zero flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lcd_hold_timer #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Load beats decrement; the count saturates at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/lcd_msg_sched.sv
// ============================================================================
// Module : lcd_msg_sched
// Desc   : Fixed-priority scheduler sharing the 2x16 LCD among keypad echo,
//          lock status and alarm. Optional macro: LCD_MSG_STICKY_ALARM_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lcd_msg_sched
  import lcd_pkg::*;
#(
  parameter int               HOLD_CYCLES = 50_000_000,
  parameter int               CNT_W       = 26,
  parameter logic [ROW_W-1:0] IDLE_ROW1   = BANNER_ROW1,
  parameter logic [ROW_W-1:0] IDLE_ROW2   = BANNER_ROW2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         req,
  input  logic [3*ROW_W-1:0] msg_row1,
  input  logic [3*ROW_W-1:0] msg_row2,
  input  logic               alarm_clr,
  output logic [2:0]         ack,
  output logic               busy,
  output logic [1:0]         cur_src,
  output logic [ROW_W-1:0]   row_1,
  output logic [ROW_W-1:0]   row_2
);

  localparam logic [CNT_W-1:0] c_reload = CNT_W'(HOLD_CYCLES - 1);

  state_t           r_state;
  logic [2:0]       r_ack;
  logic             r_busy;
  logic [1:0]       r_cur_src;
  logic [ROW_W-1:0] r_row_1;
  logic [ROW_W-1:0] r_row_2;

  logic [1:0]       w_hi;
  logic             w_any;
  logic             w_preempt;
  logic             w_regrant;
  logic             w_expire;
  logic             w_grant;
  logic             w_release;
  logic             w_zero;
  logic             w_tmr_en;
  logic [CNT_W-1:0] w_load_val;
  logic [ROW_W-1:0] w_sel1;
  logic [ROW_W-1:0] w_sel2;

  always_comb begin
    w_hi      = hi_idx(req);
    w_any     = |req;
    w_grant   = 1'b0;
    w_release = 1'b0;
    w_preempt = w_any && (w_hi > r_cur_src);
`ifdef LCD_MSG_STICKY_ALARM_EN
    // A shown alarm never times out; only alarm_clr or a fresh req[2] acts.
    w_regrant  = (r_cur_src == SRC_ALARM) && req[SRC_ALARM];
    w_expire   = (r_cur_src == SRC_ALARM) ? alarm_clr : w_zero;
    w_tmr_en   = (r_state == ST_SHOW) && (r_cur_src != SRC_ALARM);
    w_load_val = (w_hi == SRC_ALARM) ? '0 : c_reload;
`else
    w_regrant  = 1'b0;
    w_expire   = w_zero | (alarm_clr & 1'b0);
    w_tmr_en   = (r_state == ST_SHOW);
    w_load_val = c_reload;
`endif
    case (r_state)
      ST_IDLE: w_grant = w_any;
      ST_SHOW: begin
        if (w_preempt || w_regrant) begin
          w_grant = 1'b1;
        end else if (w_expire) begin
          w_grant   = w_any;
          w_release = !w_any;
        end
      end
      default: w_release = 1'b1;
    endcase

    case (w_hi)
      SRC_STATUS: begin
        w_sel1 = msg_row1[2*ROW_W-1:ROW_W];
        w_sel2 = msg_row2[2*ROW_W-1:ROW_W];
      end
      SRC_ALARM: begin
        w_sel1 = msg_row1[3*ROW_W-1:2*ROW_W];
        w_sel2 = msg_row2[3*ROW_W-1:2*ROW_W];
      end
      default: begin
        w_sel1 = msg_row1[ROW_W-1:0];
        w_sel2 = msg_row2[ROW_W-1:0];
      end
    endcase
  end

  lcd_hold_timer #(
    .CNT_W (CNT_W)
  ) u_hold_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_grant),
    .i_load_val (w_load_val),
    .i_en       (w_tmr_en),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ack     <= 3'b000;
      r_busy    <= 1'b0;
      r_cur_src <= SRC_IDLE;
      r_row_1   <= IDLE_ROW1;
      r_row_2   <= IDLE_ROW2;
    end else begin
      r_ack <= 3'b000;
      if (w_grant) begin
        r_state   <= ST_SHOW;
        r_ack     <= 3'b001 << w_hi;
        r_busy    <= 1'b1;
        r_cur_src <= w_hi;
        r_row_1   <= w_sel1;
        r_row_2   <= w_sel2;
      end else if (w_release) begin
        r_state   <= ST_IDLE;
        r_busy    <= 1'b0;
        r_cur_src <= SRC_IDLE;
        r_row_1   <= IDLE_ROW1;
        r_row_2   <= IDLE_ROW2;
      end
    end
  end

  assign ack     = r_ack;
  assign busy    = r_busy;
  assign cur_src = r_cur_src;
  assign row_1   = r_row_1;
  assign row_2   = r_row_2;

endmodule

`default_nettype wire

// File: tb/tb_lcd_msg_sched.sv
// ============================================================================
// Module : tb_lcd_msg_sched
// Desc   : Directed plus randomized bench for lcd_msg_sched against a
//          cycle-count reference model. Honours LCD_MSG_STICKY_ALARM_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lcd_msg_sched;

  localparam int HOLD = 10;
  localparam logic [127:0] BAN1 = "  DIGITAL LOCK  ";
  localparam logic [127:0] BAN2 = "  ENTER CODE    ";

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   req;
  logic [383:0] m1;
  logic [383:0] m2;
  logic         alarm_clr;
  logic [2:0]   ack;
  logic         busy;
  logic [1:0]   cur_src;
  logic [127:0] row_1;
  logic [127:0] row_2;

  always #5 clk = ~clk;

  lcd_msg_sched #(
    .HOLD_CYCLES (HOLD),
    .CNT_W       (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .msg_row1  (m1),
    .msg_row2  (m2),
    .alarm_clr (alarm_clr),
    .ack       (ack),
    .busy      (busy),
    .cur_src   (cur_src),
    .row_1     (row_1),
    .row_2     (row_2)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference: who is on screen (3 = banner), cycles left including this one.
  int           m_src = 3;
  int           m_rem = 0;
  logic [127:0] m_r1  = BAN1;
  logic [127:0] m_r2  = BAN2;
  logic [2:0]   m_ack = 3'b000;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int highest(input logic [2:0] r);
    for (int i = 2; i >= 0; i--) if (r[i]) return i;
    return -1;
  endfunction

  task automatic model_grant(input int i);
    m_r1  = m1[128*i +: 128];
    m_r2  = m2[128*i +: 128];
    m_ack = 3'b000;
    m_ack[i] = 1'b1;
    m_src = i;
    m_rem = HOLD;
  endtask

  task automatic model_step();
    int  hi;
    bit  expired;
    bit  regrant;
    hi = highest(req);
    m_ack = 3'b000;
    regrant = 1'b0;
    expired = (m_rem == 1);
`ifdef LCD_MSG_STICKY_ALARM_EN
    if (m_src == 2) begin
      expired = alarm_clr;
      regrant = req[2];
    end
`endif
    if (!rst_n) begin
      m_src = 3; m_rem = 0; m_r1 = BAN1; m_r2 = BAN2;
    end else if (m_src == 3) begin
      if (hi >= 0) model_grant(hi);
    end else if (hi > m_src || regrant) begin
      model_grant(hi);
    end else if (expired) begin
      if (hi >= 0) model_grant(hi);
      else begin
        m_src = 3; m_rem = 0; m_r1 = BAN1; m_r2 = BAN2;
      end
    end else begin
      m_rem--;
    end
  endtask

  task automatic cycle(input bit drop_on_ack);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("ack", {125'b0, ack}, {125'b0, m_ack});
    check("busy", {127'b0, busy}, {127'b0, (m_src != 3)});
    check("cur_src", {126'b0, cur_src}, 128'(m_src));
    check("row_1", row_1, m_r1);
    check("row_2", row_2, m_r2);
    if (drop_on_ack) req = req & ~m_ack;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle(1'b1);
  endtask

  task automatic randomize_payload();
    for (int k = 0; k < 12; k++) begin
      m1[32*k +: 32] = $urandom;
      m2[32*k +: 32] = $urandom;
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 3'b000; alarm_clr = 1'b0;
    m1 = '0; m2 = '0;
    m1[127:0]   = "1234            ";
    m2[127:0]   = "KEY             ";
    m1[255:128] = "LOCKED          ";
    m2[255:128] = "STATUS          ";
    m1[383:256] = "!! ALARM !!     ";
    m2[383:256] = "INTRUDER        ";
    run(2);
    rst_n = 1'b1;
    run(2);
    check("rst_row1", row_1, BAN1);
    check("rst_src", {126'b0, cur_src}, 128'd3);

    req = 3'b001; run(14);
    req = 3'b011; run(24);
    req = 3'b001; run(4);
    req[2] = 1'b1; run(14);
    req = 3'b010; run(2);
    req = 3'b001; run(24);
    req = 3'b001; run(3);
    rst_n = 1'b0; run(1);
    rst_n = 1'b1; run(3);
    req = 3'b100; run(16);
    alarm_clr = 1'b1; run(1);
    alarm_clr = 1'b0; run(4);

    for (int n = 0; n < 3000; n++) begin
      cycle(1'b0);
      for (int i = 0; i < 3; i++) begin
        if (m_ack[i] && $urandom_range(3) != 0) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(i == 2 ? 40 : 12) == 0) req[i] = 1'b1;
        else if (req[i] && $urandom_range(40) == 0) req[i] = 1'b0;
      end
      randomize_payload();
      rst_n     = ($urandom_range(299) != 0);
      alarm_clr = ($urandom_range(7) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
